// File: rtl/unsigned_divider_16by8_seq_if.sv
// Handshake bundle for the sequential unsigned divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface unsigned_divider_16by8_seq_if #(
    parameter int DW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   z;
    logic [DW-1:0]     y;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   x;
    logic [DW-1:0]     r;
    logic              dz;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, x, r, dz
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, x, r, dz
    );
endinterface

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential restoring divider: x = floor(z / y), r = z mod y, one quotient bit per clock.
// Division by zero is reported through dz with x = all ones and r = low byte of z.
module unsigned_divider_16by8_seq #(
    parameter int DW = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    unsigned_divider_16by8_seq_if.slave   bus
);
    localparam int QW = 2 * DW;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_r;
    logic              in_ready_nxt_s;
    logic              out_valid_r;
    logic              out_valid_nxt_s;
    logic [DW:0]       rem_r;
    logic [QW-1:0]     q_r;
    logic [DW-1:0]     y_r;
    logic [CW-1:0]     cnt_r;
    logic [QW-1:0]     x_r;
    logic [DW-1:0]     r_r;
    logic              dz_r;
    logic [DW+QW:0]    step_s;
    logic [DW:0]       rem_step_s;
    logic [QW-1:0]     q_step_s;

    // One restoring iteration: shift {rem, q} left, try subtracting the divisor,
    // keep the difference and set the new quotient bit only when no borrow occurs.
    // The remainder entering a step is always below d, so the shifted value fits in DW+1 bits.
    function automatic logic [DW+QW:0] restore_step(
        input logic [DW:0]   rem,
        input logic [QW-1:0] q,
        input logic [DW-1:0] d
    );
        logic [DW:0]   rem_sh;
        logic [QW-1:0] q_sh;
        logic [DW+1:0] trial;
        rem_sh = {rem[DW-1:0], q[QW-1]};
        q_sh   = {q[QW-2:0], 1'b0};
        trial  = {1'b0, rem_sh} - {2'b00, d};
        if (trial[DW+1]) begin
            restore_step = {rem_sh, q_sh};
        end else begin
            restore_step = {trial[DW:0], q_sh[QW-1:1], 1'b1};
        end
    endfunction

    assign step_s     = restore_step(rem_r, q_r, y_r);
    assign rem_step_s = step_s[DW+QW:QW];
    assign q_step_s   = step_s[QW-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: accept in IDLE, finish CALC on the last iteration, release DONE on handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.y == {DW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the handshake flags are registered.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: in_ready_nxt_s  = 1'b1;
            ST_DONE: out_valid_nxt_s = 1'b1;
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Handshake flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Datapath: operand capture, iteration, and result load; results hold until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r <= {(DW+1){1'b0}};
            q_r   <= {QW{1'b0}};
            y_r   <= {DW{1'b0}};
            cnt_r <= {CW{1'b0}};
            x_r   <= {QW{1'b0}};
            r_r   <= {DW{1'b0}};
            dz_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        y_r <= bus.y;
                        if (bus.y != {DW{1'b0}}) begin
                            q_r   <= bus.z;
                            rem_r <= {(DW+1){1'b0}};
                            cnt_r <= CW'(QW);
                        end else begin
                            x_r  <= {QW{1'b1}};
                            r_r  <= bus.z[DW-1:0];
                            dz_r <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        x_r  <= q_step_s;
                        r_r  <= rem_step_s[DW-1:0];
                        dz_r <= 1'b0;
                    end
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.x         = x_r;
    assign bus.r         = r_r;
    assign bus.dz        = dz_r;
endmodule

// File: doc/unsigned_divider_16by8_seq.md
# unsigned_divider_16by8_seq

Sequential unsigned restoring divider that computes the quotient and remainder of a 2·DW-bit product-width dividend by a DW-bit operand. It is the inverse-direction companion of the 8x8 unsigned multiplier family and shares the same operand naming: z is the product-width value, y is the operand, x is the recovered factor. It sits in the evaluation datapath and recovers the factor from exact or approximate products for error measurement. It uses a valid/ready handshake on both sides and iterates one quotient bit per clock.

## Interface
- DW, 8, divisor width; dividend and quotient are 2·DW bits, remainder is DW bits
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider idle, can accept operands
- z  input  2·DW  dividend, unsigned
- y  input  DW  divisor, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- x  output  2·DW  quotient, floor(z/y)
- r  output  DW  remainder, z − x·y
- dz  output  1  divide-by-zero flag for current result

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE. Reset values: in_ready=1, out_valid=0, x=0, r=0, dz=0, iteration counter=0.
- Outputs are registered. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: an edge with in_valid&in_ready captures z and y.
  - If y≠0, load the quotient/shift register with z, clear the partial remainder (DW+1 bits), set counter=2·DW, and go to CALC.
  - If y=0, set x=all ones, r=z[DW-1:0], dz=1, and go directly to DONE.
- CALC, one iteration per edge:
  - Shift {rem, q} left by one.
  - Compute trial = rem − {0,y}.
  - If trial is non-negative (no borrow), set rem=trial and q[0]=1. Otherwise q[0]=0.
  - Decrement counter.
  - On the edge where counter goes 1→0, also load x=q, r=rem[DW-1:0], dz=0, and go to DONE.
- DONE: x, r, dz and out_valid are held stable while out_ready=0. An edge with out_valid&out_ready moves the block to IDLE.
- x, r and dz keep their last values after the handshake until the next result is loaded. They are only meaningful while out_valid=1.
- in_valid is ignored outside IDLE. z and y are sampled only on the accept edge, so later changes have no effect.
- out_ready is ignored outside DONE.
- Arithmetic invariants for y≠0: x·y + r = z and r < y. The partial remainder is DW+1 bits wide, so it never overflows.
- Reset asserted in any state, including mid-CALC, immediately returns the block to IDLE with all reset values. The in-flight operation is discarded and no out_valid is produced for it.

## Timing
- Accept edge = edge 0.
- y≠0: iterations run on edges 1..2·DW. out_valid rises after edge 2·DW (16 for DW=8), so latency is 16 cycles.
- y=0: out_valid rises after edge 0, so latency is 1 cycle.
- Result handshake on edge k: in_ready=1 from the cycle after edge k. The earliest next accept is edge k+1.
- Throughput with y≠0 and out_ready held high: one result per 2·DW+2 cycles (18 for DW=8). No pipelining, no overlap.

## Test plan
- Basic division: z=1000, y=7, out_ready=1 → out_valid exactly 16 cycles after accept; x=142, r=6, dz=0; in_ready returns to 1 on the following cycle.
- Extreme operands:
  - z=65535, y=255 → x=257, r=0.
  - z=65535, y=1 → x=65535, r=0.
  - z=0x1234, y=0x56 → x=0x36, r=0x10.
  - z=200, y=201 → x=0, r=200.
- Divide by zero: z=0xABCD, y=0 → out_valid 1 cycle after accept; x=0xFFFF, r=0xCD, dz=1. The next operation, z=10, y=3, gives x=3, r=1, dz=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid → x, r, dz and out_valid stay stable, in_ready stays 0, and in_valid pulses during that time are ignored. Raising out_ready completes the handshake, and the block returns to IDLE.
- Reset mid-operation: assert rst asynchronously at iteration 7 of z=1000, y=7 → out_valid=0, in_ready=1, x=0, r=0 immediately. After release, z=81, y=9 yields x=9, r=0 after 16 cycles.
- Random regression: 10k random (z, y) pairs with random out_ready stalls → x·y + r = z and r < y for every y≠0, with exactly one result per accepted operation.
